// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
//   Shared TMDS definitions: the four control-token characters (also used by
//   tmds_encoder), the word-alignment FSM state encoding and small helpers for
//   recognising a control token and extracting its {C1,C0} value.
//   No ports (package).
// -----------------------------------------------------------------------------
package tmds_pkg;

  // Control tokens, written bit 9 down to bit 0 (bit 0 is first on the wire).
  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

  // Word-alignment FSM states; encoding 2'd3 is unused and recovers to SEARCH.
  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } align_state_e;

  function automatic logic is_ctrl_token(input logic [9:0] word);
    return (word == TOKEN_C00) || (word == TOKEN_C01) ||
           (word == TOKEN_C10) || (word == TOKEN_C11);
  endfunction

  function automatic logic [1:0] token_value(input logic [9:0] word);
    logic [1:0] val;
    val = 2'b00;
    case (word)
      TOKEN_C01: val = 2'b01;
      TOKEN_C10: val = 2'b10;
      TOKEN_C11: val = 2'b11;
      default:   val = 2'b00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/tmds_align_fsm.sv
// -----------------------------------------------------------------------------
// tmds_align_fsm
//   Word-alignment controller for one TMDS channel. Counts consecutive control
//   tokens (blanking), declares lock after LOCK_COUNT of them, and requests a
//   one-bit word-boundary shift from the deserializer when no qualifying run is
//   seen for SEARCH_TIMEOUT cycles. While locked, the same timeout drops lock.
// Ports
//   clk_i            in  1  pixel clock
//   reset_i          in  1  asynchronous reset, active-high
//   is_ctrl_token_i  in  1  stage-1 word is one of the four control tokens
//   locked_o         out 1  word alignment achieved
//   bitslip_o        out 1  one-cycle pulse: shift word boundary by one bit
// -----------------------------------------------------------------------------
module tmds_align_fsm
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT     = 12,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int SLIP_SETTLE    = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic is_ctrl_token_i,
  output logic locked_o,
  output logic bitslip_o
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam int TMR_W = $clog2(SEARCH_TIMEOUT + 1);

  localparam logic [RUN_W-1:0] RUN_MAX      = RUN_W'(LOCK_COUNT);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(SEARCH_TIMEOUT - 1);
  // The timer doubles as the settle counter while in SLIP_WAIT.
  localparam logic [TMR_W-1:0] SETTLE_LAST  = TMR_W'(SLIP_SETTLE - 1);

  align_state_e     state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             locked_q, locked_d;
  logic             bitslip_q, bitslip_d;
  logic             run_full;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_SEARCH;
      run_q     <= '0;
      timer_q   <= '0;
      locked_q  <= 1'b0;
      bitslip_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      timer_q   <= timer_d;
      locked_q  <= locked_d;
      bitslip_q <= bitslip_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    timer_d   = timer_q;
    locked_d  = locked_q;
    bitslip_d = 1'b0;
    run_full  = 1'b0;

    // Run counter: input is ignored while the deserializer settles after a slip.
    if (state_q == ST_SLIP_WAIT) begin
      run_d = '0;
    end else if (is_ctrl_token_i) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
    end else begin
      run_d = '0;
    end

    // Decide on the updated run so lock lands one cycle after stage 1.
    run_full = (run_d == RUN_MAX);

    case (state_q)
      ST_SEARCH: begin
        // Lock takes priority over a coincident timeout.
        if (run_full) begin
          state_d  = ST_LOCKED;
          timer_d  = '0;
          locked_d = 1'b1;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d   = ST_SLIP_WAIT;
          timer_d   = '0;
          bitslip_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_SLIP_WAIT: begin
        if (timer_q == SETTLE_LAST) begin
          state_d = ST_SEARCH;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_LOCKED: begin
        // Each full token run during blanking re-arms the loss-of-lock timer.
        if (run_full) begin
          timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d  = ST_SEARCH;
          timer_d  = '0;
          locked_d = 1'b0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      default: begin
        state_d  = ST_SEARCH;
        run_d    = '0;
        timer_d  = '0;
        locked_d = 1'b0;
      end
    endcase
  end

  assign locked_o  = locked_q;
  assign bitslip_o = bitslip_q;

endmodule

// File: rtl/tmds_decoder.sv
// -----------------------------------------------------------------------------
// tmds_decoder
//   Receive side of one HDMI/DVI TMDS channel. Registers the 10-bit character
//   (stage 1), decodes it into pixel data or a control word (stage 2, fixed
//   2-clock latency) and runs word alignment via tmds_align_fsm. Decoding is
//   never gated by lock.
// Ports
//   clk_i      in  1   pixel clock
//   reset_i    in  1   asynchronous reset, active-high
//   tmds_i     in  10  TMDS character, bit 0 first on the wire
//   data_o     out 8   decoded pixel data (held during control periods)
//   ctrl_o     out 2   decoded control word {C1,C0} (held during data periods)
//   disp_en_o  out 1   1 = data character decoded, 0 = control token
//   locked_o   out 1   word alignment achieved
//   bitslip_o  out 1   one-cycle pulse to shift the deserializer boundary
// -----------------------------------------------------------------------------
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT     = 12,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int SLIP_SETTLE    = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [9:0] tmds_i,
  output logic [7:0] data_o,
  output logic [1:0] ctrl_o,
  output logic       disp_en_o,
  output logic       locked_o,
  output logic       bitslip_o
);

  logic [9:0] tmds_q;
  logic [7:0] data_q, data_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic       disp_en_q, disp_en_d;

  logic       token;
  logic [7:0] d_word;
  logic [7:0] data_dec;

  // Stage 1: capture the raw character.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tmds_q <= '0;
    end else begin
      tmds_q <= tmds_i;
    end
  end

  assign token = is_ctrl_token(tmds_q);

  // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8).
  assign d_word      = tmds_q[9] ? ~tmds_q[7:0] : tmds_q[7:0];
  assign data_dec[0] = d_word[0];

  for (genvar gi = 1; gi < 8; gi++) begin : g_dec_bit
    assign data_dec[gi] = tmds_q[8] ? (d_word[gi] ^ d_word[gi-1])
                                    : ~(d_word[gi] ^ d_word[gi-1]);
  end

  always_comb begin
    data_d    = data_q;
    ctrl_d    = ctrl_q;
    disp_en_d = 1'b0;
    if (token) begin
      ctrl_d = token_value(tmds_q);
    end else begin
      data_d    = data_dec;
      disp_en_d = 1'b1;
    end
  end

  // Stage 2: decoded outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_q    <= '0;
      ctrl_q    <= '0;
      disp_en_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      ctrl_q    <= ctrl_d;
      disp_en_q <= disp_en_d;
    end
  end

  tmds_align_fsm #(
    .LOCK_COUNT     (LOCK_COUNT),
    .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
    .SLIP_SETTLE    (SLIP_SETTLE)
  ) u_align (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .is_ctrl_token_i (token),
    .locked_o        (locked_o),
    .bitslip_o       (bitslip_o)
  );

  assign data_o    = data_q;
  assign ctrl_o    = ctrl_q;
  assign disp_en_o = disp_en_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// -----------------------------------------------------------------------------
// tb_tmds_decoder
//   Directed bench for tmds_decoder. A behavioural DVI encoder model (with
//   running disparity) produces the characters; a rotator model emulates a
//   misaligned deserializer that honours bitslip requests.
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_tmds_decoder;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [9:0] tmds_i;
  logic [7:0] data_o;
  logic [1:0] ctrl_o;
  logic       disp_en_o;
  logic       locked_o;
  logic       bitslip_o;

  int n_checks = 0;
  int n_fail   = 0;
  int enc_cnt  = 0;

  tmds_decoder dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .tmds_i    (tmds_i),
    .data_o    (data_o),
    .ctrl_o    (ctrl_o),
    .disp_en_o (disp_en_o),
    .locked_o  (locked_o),
    .bitslip_o (bitslip_o)
  );

  always #5 clk_i = ~clk_i;

  // DVI 1.0 TMDS data encoder with running disparity.
  task automatic enc_data(input logic [7:0] d, output logic [9:0] w);
    logic [8:0] qm;
    int n1d, n1q, n0q;
    n1d   = $countones(d);
    qm    = '0;
    qm[0] = d[0];
    if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_cnt == 0 || n1q == n0q) begin
      w = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      if (qm[8] == 1'b0) enc_cnt = enc_cnt + n0q - n1q;
      else               enc_cnt = enc_cnt + n1q - n0q;
    end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
      w = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt = enc_cnt + (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      w = {1'b0, qm[8], qm[7:0]};
      enc_cnt = enc_cnt - (qm[8] ? 0 : 2) + n1q - n0q;
    end
  endtask

  // Word seen by a deserializer whose boundary is k bits off a repeating character.
  function automatic logic [9:0] rot(input logic [9:0] w, input int k);
    logic [19:0] dbl;
    dbl = {w, w} >> k;
    return dbl[9:0];
  endfunction

  task automatic test_reset();
    reset_i = 1'b1;
    tmds_i  = '0;
    repeat (3) @(negedge clk_i);
    n_checks++;
    if ({data_o, ctrl_o, disp_en_o, locked_o, bitslip_o} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_state: got data=%h ctrl=%b de=%b lk=%b bs=%b, expected all 0",
               data_o, ctrl_o, disp_en_o, locked_o, bitslip_o);
    end
  endtask

  // Called with reset asserted: releases it and sends 16 x token 00.
  task automatic test_token_lock(input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      if (i >= 2) begin
        n_checks++;
        if (disp_en_o !== 1'b0 || ctrl_o !== 2'b00) begin
          n_fail++;
          $display("FAIL %s_ctrl00 [%0d]: got de=%b ctrl=%b, expected de=0 ctrl=00",
                   tag, i, disp_en_o, ctrl_o);
        end
      end
      if (i == 12) begin
        n_checks++;
        if (locked_o !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_early_lock: got locked=%b, expected 0", tag, locked_o);
        end
      end
      if (i == 13) begin
        n_checks++;
        if (locked_o !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_lock: got locked=%b, expected 1", tag, locked_o);
        end
      end
      if (i == 0) reset_i = 1'b0;
      tmds_i  = T00;
      enc_cnt = 0;
    end
  endtask

  task automatic test_data_sweep();
    logic [7:0] sent [258];
    logic [9:0] w;
    for (int i = 0; i < 258; i++) begin
      @(negedge clk_i);
      if (i >= 2) begin
        n_checks++;
        if ({disp_en_o, ctrl_o, data_o} !== {1'b1, 2'b00, sent[i-2]}) begin
          n_fail++;
          $display("FAIL data_sweep [%0d]: got de=%b ctrl=%b data=%h, expected de=1 ctrl=00 data=%h",
                   i - 2, disp_en_o, ctrl_o, data_o, sent[i-2]);
        end
      end
      sent[i] = (i < 256) ? 8'(i) : 8'hFF;
      enc_data(sent[i], w);
      tmds_i = w;
    end
    n_checks++;
    if (locked_o !== 1'b1) begin
      n_fail++;
      $display("FAIL sweep_keeps_lock: got locked=%b, expected 1", locked_o);
    end
  endtask

  task automatic test_ctrl_tokens();
    logic [9:0] words [6];
    logic [1:0] exp_ctrl [4];
    words    = '{T01, T10, T11, T00, T00, T00};
    exp_ctrl = '{2'b01, 2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (i >= 2) begin
        n_checks++;
        if ({disp_en_o, ctrl_o, data_o} !== {1'b0, exp_ctrl[i-2], 8'hFF}) begin
          n_fail++;
          $display("FAIL ctrl_token [%0d]: got de=%b ctrl=%b data=%h, expected de=0 ctrl=%b data=ff",
                   i - 2, disp_en_o, ctrl_o, data_o, exp_ctrl[i-2]);
        end
      end
      tmds_i  = words[i];
      enc_cnt = 0;
    end
  endtask

  task automatic test_lock_loss();
    int         fall_idx;
    bit         slip_seen;
    logic [9:0] w;
    fall_idx  = -1;
    slip_seen = 1'b0;
    repeat (16) begin
      @(negedge clk_i);
      tmds_i  = T00;
      enc_cnt = 0;
    end
    for (int i = 0; i <= 4110; i++) begin
      @(negedge clk_i);
      if (locked_o !== 1'b1 && fall_idx < 0) fall_idx = i;
      if (bitslip_o !== 1'b0) slip_seen = 1'b1;
      enc_data(8'(i), w);
      tmds_i = w;
    end
    n_checks++;
    if (fall_idx != 4097) begin
      n_fail++;
      $display("FAIL lock_loss_time: got fall at data cycle %0d, expected 4097", fall_idx);
    end
    n_checks++;
    if (slip_seen) begin
      n_fail++;
      $display("FAIL lock_loss_bitslip: got bitslip=1, expected 0 throughout");
    end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      if (i == 15) begin
        n_checks++;
        if (locked_o !== 1'b1) begin
          n_fail++;
          $display("FAIL relock_before_reset: got locked=%b, expected 1", locked_o);
        end
      end
      tmds_i  = T00;
      enc_cnt = 0;
    end
    #2 reset_i = 1'b1;
    #1;
    n_checks++;
    if ({data_o, ctrl_o, disp_en_o, locked_o, bitslip_o} !== 13'h0) begin
      n_fail++;
      $display("FAIL async_reset: got data=%h ctrl=%b de=%b lk=%b bs=%b, expected all 0",
               data_o, ctrl_o, disp_en_o, locked_o, bitslip_o);
    end
    @(negedge clk_i);
    test_token_lock("after_reset");
  endtask

  task automatic test_misaligned_slip();
    int pulses [8];
    int np;
    int lock_idx;
    int off;
    np       = 0;
    lock_idx = -1;
    off      = 7;
    reset_i  = 1'b1;
    tmds_i   = rot(T00, off);
    repeat (2) @(negedge clk_i);
    for (int k = 0; k <= 12400; k++) begin
      @(negedge clk_i);
      if (k == 0) begin
        reset_i = 1'b0;
      end else begin
        if (bitslip_o === 1'b1) begin
          if (np < 8) pulses[np] = k;
          np++;
          off = (off + 1) % 10;
        end
        if (locked_o === 1'b1 && lock_idx < 0) lock_idx = k;
      end
      tmds_i = rot(T00, off);
    end
    n_checks++;
    if (np != 3) begin
      n_fail++;
      $display("FAIL slip_count: got %0d pulses, expected 3", np);
    end
    n_checks++;
    if (np < 3 || pulses[0] != 4096 || pulses[1] != 8196 || pulses[2] != 12296) begin
      n_fail++;
      $display("FAIL slip_timing: got pulses at %0d,%0d,%0d, expected 4096,8196,12296",
               pulses[0], pulses[1], pulses[2]);
    end
    n_checks++;
    if (lock_idx != 12312) begin
      n_fail++;
      $display("FAIL slip_lock: got lock at cycle %0d, expected 12312", lock_idx);
    end
  endtask

  initial begin
    pulse_guard_init();
  end

  task automatic pulse_guard_init();
    reset_i = 1'b1;
    tmds_i  = '0;
  endtask

  initial begin
    #1;
    test_reset();
    test_token_lock("token_lock");
    test_data_sweep();
    test_ctrl_tokens();
    test_lock_loss();
    test_reset_mid_run();
    test_misaligned_slip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
